// File: rtl/maria_dma_pkg.sv
// rtl/maria_dma_pkg.sv - shared types and constants for the Maria DLL fetch path
package maria_dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_F0,
        ST_F1,
        ST_F2,
        ST_READY
    } dll_state_t;

    typedef struct packed {
        logic       dli;
        logic [1:0] holey;
        logic       rsvd;
        logic [3:0] offset;
        logic [7:0] dl_hi;
        logic [7:0] dl_lo;
    } dll_entry_t;

    localparam logic [1:0] DEF_DMA_ON_CODE = 2'b10;
    localparam int         DLL_ENTRY_BYTES = 3;

endpackage

// File: rtl/dll_byte_reader.sv
// rtl/dll_byte_reader.sv - single-byte request/acknowledge read engine
module dll_byte_reader (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_data,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    output logic [7:0]  rd_byte,
    output logic        done
);

    // An ack only counts against an outstanding request; mem_req itself stays registered.
    assign done    = mem_req & mem_ack;
    assign rd_byte = mem_data;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            mem_req  <= 1'b0;
            mem_addr <= 16'h0000;
        end else if (start) begin
            mem_req  <= 1'b1;
            mem_addr <= addr;
        end else if (abort || done) begin
            mem_req  <= 1'b0;
        end
    end

endmodule

// File: rtl/dll_fetch.sv
// rtl/dll_fetch.sv - Maria display-list-list walker; DLL_PREFETCH_EN enables shadow-entry prefetch
module dll_fetch
    import maria_dma_pkg::*;
#(
    parameter int         ZONE_LIMIT  = 256,
    parameter logic [1:0] DMA_ON_CODE = DEF_DMA_ON_CODE
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [7:0]  ctrl,
    input  logic [15:0] zp,
    input  logic        frame_start,
    input  logic        line_start,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_data,
    output logic [15:0] dl_ptr,
    output logic [3:0]  dl_offset,
    output logic [1:0]  dl_holey,
    output logic        dl_valid,
    output logic        dli,
    output logic        busy
);

`ifdef DLL_PREFETCH_EN
    localparam bit PREFETCH = 1'b1;
`else
    localparam bit PREFETCH = 1'b0;
`endif

    localparam int CW = $clog2(ZONE_LIMIT + 1);

    dll_state_t    state;
    logic [15:0]   dll_ptr;
    logic [CW-1:0] zone_cnt;
    logic          line_pending;
    logic          cur_dli;
    logic [7:0]    b0;
    logic [7:0]    b1;

    logic          pf_active;
    logic [1:0]    pf_idx;
    logic [15:0]   pf_base;
    logic          sh_valid;
    logic [15:0]   sh_ptr;
    logic [3:0]    sh_offset;
    logic [1:0]    sh_holey;
    logic          sh_dli;

    logic          rd_start;
    logic [15:0]   rd_addr;
    logic [7:0]    rd_byte;
    logic          rd_done;

    logic          dma_on;
    logic [15:0]   next_ptr;
    dll_entry_t    entry;
    logic          pend_now;
    logic          load_zero;
    logic          can_fetch;
    logic          cnt_next_ok;
    logic          pf_fin;
    logic          sh_ready;
    logic          pf_next_ok;
    logic [15:0]   pf_addr;
    logic [15:0]   swap_ptr;
    logic [3:0]    swap_ofs;
    logic [1:0]    swap_holey;
    logic          swap_dli;
    logic          unused_bits;

    // Only ctrl[6:5] and the documented entry fields matter; the rest is deliberately ignored.
    assign unused_bits = ^{ctrl[7], ctrl[4:0], entry.rsvd, DLL_ENTRY_BYTES[0]};

    assign dma_on      = (ctrl[6:5] == DMA_ON_CODE);
    assign next_ptr    = dll_ptr + 16'd1;
    assign entry       = {b0, b1, rd_byte};
    assign pend_now    = line_pending | line_start;
    assign load_zero   = (entry.offset == 4'd0) || (pend_now && entry.offset == 4'd1);
    assign can_fetch   = int'(zone_cnt) < ZONE_LIMIT;
    assign cnt_next_ok = (int'(zone_cnt) + 1) < ZONE_LIMIT;
    assign busy        = (state == ST_F0) || (state == ST_F1) || (state == ST_F2);

    // A prefetch finishing on the very cycle of the zone boundary is usable immediately.
    assign pf_fin      = PREFETCH && (state == ST_READY) && pf_active && rd_done && (pf_idx == 2'd2);
    assign sh_ready    = sh_valid | pf_fin;
    assign pf_next_ok  = (int'(zone_cnt) + (pf_fin ? 1 : 0)) < ZONE_LIMIT;
    assign pf_addr     = pf_fin ? next_ptr : dll_ptr;
    assign swap_ptr    = sh_valid ? sh_ptr    : {entry.dl_hi, entry.dl_lo};
    assign swap_ofs    = sh_valid ? sh_offset : entry.offset;
    assign swap_holey  = sh_valid ? sh_holey  : entry.holey;
    assign swap_dli    = sh_valid ? sh_dli    : entry.dli;

    always_comb begin
        rd_start = 1'b0;
        rd_addr  = dll_ptr;
        if (dma_on) begin
            if (frame_start) begin
                rd_start = 1'b1;
                rd_addr  = zp;
            end else begin
                case (state)
                    ST_F0, ST_F1: begin
                        if (rd_done) begin
                            rd_start = 1'b1;
                            rd_addr  = next_ptr;
                        end
                    end
                    ST_F2: begin
                        if (rd_done && cnt_next_ok &&
                            (PREFETCH || (pend_now && entry.offset == 4'd0))) begin
                            rd_start = 1'b1;
                            rd_addr  = next_ptr;
                        end
                    end
                    ST_READY: begin
                        if (PREFETCH && pf_active && rd_done && pf_idx != 2'd2) begin
                            rd_start = 1'b1;
                            rd_addr  = next_ptr;
                        end
                        if (line_start && dl_offset == 4'd0) begin
                            if (PREFETCH && sh_ready) begin
                                rd_start = pf_next_ok;
                                rd_addr  = pf_addr;
                            end else if (PREFETCH && pf_active) begin
                                rd_start = 1'b1;
                                rd_addr  = pf_base;
                            end else if (can_fetch) begin
                                rd_start = 1'b1;
                                rd_addr  = dll_ptr;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    dll_byte_reader u_reader (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .start    (rd_start),
        .abort    (!dma_on),
        .addr     (rd_addr),
        .mem_ack  (mem_ack),
        .mem_data (mem_data),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .rd_byte  (rd_byte),
        .done     (rd_done)
    );

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            dll_ptr      <= 16'h0000;
            zone_cnt     <= '0;
            line_pending <= 1'b0;
            cur_dli      <= 1'b0;
            b0           <= 8'h00;
            b1           <= 8'h00;
            dl_ptr       <= 16'h0000;
            dl_offset    <= 4'd0;
            dl_holey     <= 2'd0;
            dl_valid     <= 1'b0;
            dli          <= 1'b0;
            pf_active    <= 1'b0;
            pf_idx       <= 2'd0;
            pf_base      <= 16'h0000;
            sh_valid     <= 1'b0;
            sh_ptr       <= 16'h0000;
            sh_offset    <= 4'd0;
            sh_holey     <= 2'd0;
            sh_dli       <= 1'b0;
        end else begin
            dli <= 1'b0;
            if (!dma_on) begin
                state        <= ST_IDLE;
                dl_valid     <= 1'b0;
                line_pending <= 1'b0;
                pf_active    <= 1'b0;
                sh_valid     <= 1'b0;
            end else if (frame_start) begin
                state        <= ST_F0;
                dll_ptr      <= zp;
                zone_cnt     <= '0;
                dl_valid     <= 1'b0;
                line_pending <= 1'b0;
                pf_active    <= 1'b0;
                sh_valid     <= 1'b0;
            end else begin
                case (state)
                    ST_F0: begin
                        if (line_start) line_pending <= 1'b1;
                        if (rd_done) begin
                            b0      <= rd_byte;
                            dll_ptr <= next_ptr;
                            state   <= ST_F1;
                        end
                    end
                    ST_F1: begin
                        if (line_start) line_pending <= 1'b1;
                        if (rd_done) begin
                            b1      <= rd_byte;
                            dll_ptr <= next_ptr;
                            state   <= ST_F2;
                        end
                    end
                    ST_F2: begin
                        if (line_start) line_pending <= 1'b1;
                        if (rd_done) begin
                            dll_ptr      <= next_ptr;
                            pf_base      <= next_ptr;
                            zone_cnt     <= zone_cnt + CW'(1);
                            line_pending <= 1'b0;
                            dl_ptr       <= {entry.dl_hi, entry.dl_lo};
                            dl_holey     <= entry.holey;
                            cur_dli      <= entry.dli;
                            dli          <= entry.dli && load_zero;
                            // A line that began mid-fetch consumes one line of the new entry.
                            if (pend_now && entry.offset == 4'd0) begin
                                dl_offset <= 4'd0;
                                dl_valid  <= 1'b0;
                                state     <= cnt_next_ok ? ST_F0 : ST_IDLE;
                            end else begin
                                dl_offset <= pend_now ? entry.offset - 4'd1 : entry.offset;
                                dl_valid  <= 1'b1;
                                state     <= ST_READY;
                                pf_active <= PREFETCH && cnt_next_ok;
                                pf_idx    <= 2'd0;
                            end
                        end
                    end
                    ST_READY: begin
                        if (PREFETCH && pf_active && rd_done) begin
                            dll_ptr <= next_ptr;
                            pf_idx  <= pf_idx + 2'd1;
                            if (pf_idx == 2'd0) begin
                                b0 <= rd_byte;
                            end else if (pf_idx == 2'd1) begin
                                b1 <= rd_byte;
                            end else begin
                                sh_ptr    <= {entry.dl_hi, entry.dl_lo};
                                sh_offset <= entry.offset;
                                sh_holey  <= entry.holey;
                                sh_dli    <= entry.dli;
                                sh_valid  <= 1'b1;
                                pf_active <= 1'b0;
                                zone_cnt  <= zone_cnt + CW'(1);
                            end
                        end
                        if (line_start) begin
                            if (dl_offset != 4'd0) begin
                                dl_offset <= dl_offset - 4'd1;
                                dli       <= cur_dli && (dl_offset == 4'd1);
                            end else if (PREFETCH && sh_ready) begin
                                dl_ptr    <= swap_ptr;
                                dl_offset <= swap_ofs;
                                dl_holey  <= swap_holey;
                                cur_dli   <= swap_dli;
                                dli       <= swap_dli && (swap_ofs == 4'd0);
                                sh_valid  <= 1'b0;
                                pf_active <= pf_next_ok;
                                pf_idx    <= 2'd0;
                                pf_base   <= pf_addr;
                            end else if (PREFETCH && pf_active) begin
                                // Shadow not ready yet: restart the entry as a normal fetch.
                                dl_valid  <= 1'b0;
                                dll_ptr   <= pf_base;
                                pf_active <= 1'b0;
                                state     <= ST_F0;
                            end else begin
                                dl_valid  <= 1'b0;
                                state     <= can_fetch ? ST_F0 : ST_IDLE;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dll_fetch.sv
// tb/tb_dll_fetch.sv - directed self-checking bench for dll_fetch
module tb_dll_fetch;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic [7:0]  ctrl;
    logic [15:0] zp;
    logic        frame_start;
    logic        line_start;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_data;
    logic [15:0] dl_ptr;
    logic [3:0]  dl_offset;
    logic [1:0]  dl_holey;
    logic        dl_valid;
    logic        dli;
    logic        busy;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  mem [0:65535];
    logic        stray_ack = 1'b0;
    int          wait_cnt  = 0;

    always #5 clk_sys = ~clk_sys;

    dll_fetch dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .ctrl        (ctrl),
        .zp          (zp),
        .frame_start (frame_start),
        .line_start  (line_start),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_data    (mem_data),
        .dl_ptr      (dl_ptr),
        .dl_offset   (dl_offset),
        .dl_holey    (dl_holey),
        .dl_valid    (dl_valid),
        .dli         (dli),
        .busy        (busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return {22'd0, mem_req, mem_addr, dl_ptr, dl_offset, dl_holey, dl_valid, dli, busy};
    endfunction

    task automatic pulse_frame();
        @(negedge clk_sys);
        frame_start = 1'b1;
        @(negedge clk_sys);
        frame_start = 1'b0;
    endtask

    task automatic pulse_line();
        @(negedge clk_sys);
        line_start = 1'b1;
        @(negedge clk_sys);
        line_start = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (dl_valid !== 1'b1 && n < 60) begin
            @(negedge clk_sys);
            n++;
        end
        check(tag, dl_valid, 64'd1);
    endtask

    task automatic wait_addr(input string tag, input logic [15:0] a);
        int n = 0;
        while (!(mem_req === 1'b1 && mem_addr === a) && n < 60) begin
            @(negedge clk_sys);
            n++;
        end
        check(tag, {mem_req, mem_addr}, {1'b1, a});
    endtask

    // Memory model: acks every request two cycles after it is seen, data valid with the ack.
    initial begin
        mem_ack  = 1'b0;
        mem_data = 8'h00;
        forever begin
            @(negedge clk_sys);
            mem_ack = 1'b0;
            if (stray_ack) begin
                mem_ack   = 1'b1;
                mem_data  = 8'hEE;
                stray_ack = 1'b0;
                wait_cnt  = 0;
            end else if (mem_req) begin
                wait_cnt++;
                if (wait_cnt == 2) begin
                    mem_ack  = 1'b1;
                    mem_data = mem[mem_addr];
                    wait_cnt = 0;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h1800] = 8'h82; mem[16'h1801] = 8'h20; mem[16'h1802] = 8'h00;
        mem[16'h1803] = 8'h00; mem[16'h1804] = 8'h30; mem[16'h1805] = 8'h40;
        mem[16'hFFFE] = 8'h01; mem[16'hFFFF] = 8'h12; mem[16'h0000] = 8'h34;
        mem[16'h0001] = 8'h63; mem[16'h0002] = 8'h55; mem[16'h0003] = 8'h66;
        mem[16'h0004] = 8'h03; mem[16'h0005] = 8'h77; mem[16'h0006] = 8'h88;
        mem[16'h2000] = 8'h05; mem[16'h2001] = 8'hAB; mem[16'h2002] = 8'hCD;
        mem[16'h3000] = 8'h00; mem[16'h3001] = 8'h11; mem[16'h3002] = 8'h22;
        mem[16'h3003] = 8'h00; mem[16'h3004] = 8'h33; mem[16'h3005] = 8'h44;

        reset_n     = 1'b0;
        ctrl        = 8'h00;
        zp          = 16'h0000;
        frame_start = 1'b0;
        line_start  = 1'b0;
        repeat (3) @(negedge clk_sys);
        check("reset_outs", outs(), 64'd0);
        reset_n = 1'b1;

        // Basic walk with DLI on the last line of the zone
        ctrl = 8'h40;
        zp   = 16'h1800;
        pulse_frame();
        check("t1_req", {mem_req, mem_addr, busy}, {1'b1, 16'h1800, 1'b1});
        wait_valid("t1_valid");
        check("t1_entry", {dl_ptr, dl_offset, dl_holey, busy, mem_req},
              {16'h2000, 4'd2, 2'd0, 1'b0, 1'b0});
        pulse_line();
        check("t1_ofs1", {dl_offset, dli, dl_valid}, {4'd1, 1'b0, 1'b1});
        pulse_line();
        check("t1_dli", {dl_offset, dli, dl_valid}, {4'd0, 1'b1, 1'b1});
        @(negedge clk_sys);
        check("t1_dli_end", dli, 64'd0);
        pulse_line();
        check("t1_refetch", {mem_req, mem_addr, dl_valid, busy}, {1'b1, 16'h1803, 1'b0, 1'b1});
        wait_valid("t1_valid2");
        check("t1_entry2", {dl_ptr, dl_offset}, {16'h3040, 4'd0});

        // Address wrap FFFF -> 0000
        zp = 16'hFFFE;
        pulse_frame();
        check("t2_first_addr", {mem_req, mem_addr}, {1'b1, 16'hFFFE});
        wait_addr("t2_wrap_addr", 16'h0000);
        wait_valid("t2_valid");
        check("t2_entry", {dl_ptr, dl_offset}, {16'h1234, 4'd1});
        pulse_line();
        check("t2_ofs0", {dl_offset, dli}, {4'd0, 1'b0});
        pulse_line();
        check("t2_next_addr", {mem_req, mem_addr}, {1'b1, 16'h0001});

        // line_start between F1 ack and F2 ack
        wait_addr("t3_f2_addr", 16'h0003);
        line_start = 1'b1;
        @(negedge clk_sys);
        line_start = 1'b0;
        wait_valid("t3_valid");
        check("t3_pending", {dl_ptr, dl_offset, dl_holey}, {16'h5566, 4'd2, 2'd3});
        pulse_line();
        pulse_line();
        pulse_line();
        check("t3_next_addr", {mem_req, mem_addr}, {1'b1, 16'h0004});
        pulse_line();
        pulse_line();
        wait_valid("t3_valid2");
        check("t3_double", {dl_ptr, dl_offset}, {16'h7788, 4'd2});

        // DMA switched off mid-fetch
        zp = 16'h2000;
        pulse_frame();
        wait_addr("t4_f1_addr", 16'h2001);
        ctrl = 8'h60;
        @(negedge clk_sys);
        check("t4_off", {mem_req, dl_valid, busy}, 64'd0);
        stray_ack = 1'b1;
        repeat (3) @(negedge clk_sys);
        check("t4_stray", {mem_req, dl_valid, busy}, 64'd0);
        ctrl = 8'h40;
        pulse_frame();
        check("t4_restart", {mem_req, mem_addr}, {1'b1, 16'h2000});
        wait_valid("t4_valid");
        check("t4_entry", {dl_ptr, dl_offset}, {16'hABCD, 4'd5});

        // Asynchronous reset in F2
        pulse_frame();
        wait_addr("t5_f2_addr", 16'h2002);
        #2 reset_n = 1'b0;
        #1;
        check("t5_async", outs(), 64'd0);
        repeat (2) @(negedge clk_sys);
        reset_n = 1'b1;
        repeat (5) @(negedge clk_sys);
        check("t5_post", outs(), 64'd0);
        pulse_line();
        check("t5_line_idle", outs(), 64'd0);

        // Zone boundary with offset-0 entries
        zp = 16'h3000;
        pulse_frame();
        wait_valid("t6_valid");
        check("t6_entry", dl_ptr, {48'd0, 16'h1122});
        repeat (20) @(negedge clk_sys);
        pulse_line();
`ifdef DLL_PREFETCH_EN
        check("t6_swap", {dl_valid, dl_ptr}, {1'b1, 16'h3344});
`else
        check("t6_gap", {dl_valid, mem_req, mem_addr}, {1'b0, 1'b1, 16'h3003});
        wait_valid("t6_valid2");
        check("t6_entry2", dl_ptr, {48'd0, 16'h3344});
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dll_fetch.md
Name: dll_fetch

Overview:
- Display-list-list (DLL) fetch engine for Maria, directly downstream of the Maria register block.
- Consumes the ZP (DLL base) pointer and the DMA-mode bits of ctrl, and walks the DLL in memory over a request/acknowledge bus.
- Presents the current zone's display-list pointer, offset, holey mode and DLI request to the line-builder DMA stage.

Parameters:
- ZONE_LIMIT, 256: max DLL entries fetched per frame; further offset-zero line_starts leave the pipeline idle (dl_valid stays 0).
- DMA_ON_CODE, 2'b10: ctrl[6:5] value meaning "DMA enabled".

Ports:
- clk_sys  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- ctrl  in  8  Maria ctrl register; bits [6:5] gate DMA
- zp  in  16  DLL base address {ZPH,ZPL}
- frame_start  in  1  one-cycle pulse at last VBLANK line; restarts DLL walk
- line_start  in  1  one-cycle pulse at start of each visible line
- mem_req  out  1  memory read request
- mem_addr  out  16  read address, stable while mem_req=1
- mem_ack  in  1  one-cycle ack; mem_data valid the same cycle
- mem_data  in  8  read data
- dl_ptr  out  16  current display-list address {byte1,byte2}
- dl_offset  out  4  current line offset within zone
- dl_holey  out  2  holey DMA mode (entry byte0[6:5])
- dl_valid  out  1  dl_ptr/offset/holey valid for the current line
- dli  out  1  one-cycle pulse: last line of a zone whose DLI bit is set
- busy  out  1  fetch in progress

Behaviour:
- Reset values (async, reset_n=0): all outputs 0; state IDLE; internal dll_ptr=0, zone_cnt=0, line_pending=0.
- dma_on = (ctrl[6:5]==DMA_ON_CODE), sampled every cycle.
- DLL entry format:
  - byte0: [7]=DLI, [6:5]=holey, [4]=reserved (ignored), [3:0]=offset.
  - byte1 = DL high; byte2 = DL low.
- States: IDLE, F0, F1, F2, READY.
- frame_start with dma_on:
  - dll_ptr<=zp, zone_cnt<=0, dl_valid<=0, enter F0.
  - Has priority over everything, including mid-fetch; any outstanding req is dropped and restarted.
- F0/F1/F2:
  - mem_req=1, mem_addr=dll_ptr.
  - On mem_ack: latch byte, dll_ptr<=dll_ptr+1 (16-bit wrap, FFFF->0000), advance to next state.
  - F2 ack -> READY: dl_valid<=1, offset<=byte0[3:0], zone_cnt+1.
  - mem_req deasserts the cycle after the F2 ack; ack without req is ignored.
- READY, on line_start:
  - If offset!=0: offset<=offset-1, dl_valid stays 1.
  - If offset==0: dl_valid<=0; enter F0 if zone_cnt<ZONE_LIMIT, else IDLE.
- dli: pulses the cycle after a line_start that leaves offset==0 (0 reached from 1, or entry loaded with offset 0) with DLI=1.
- line_start during F0-F2: set line_pending. It is consumed on READY entry as one decrement (offset-1; 0 -> refetch).
  - A second pending line_start while still fetching is dropped.
- dma_on falls: within 1 cycle go to IDLE; mem_req, dl_valid, busy -> 0; line_pending cleared; dli suppressed.
- busy = (state in F0..F2).
- No combinational path from mem_ack to mem_req.

Optional Feature:
- Macro: DLL_PREFETCH_EN.
- Defined:
  - After entering READY, the next entry is fetched immediately into a shadow register.
  - On an offset==0 line_start, shadow swaps into the outputs in the same cycle; dl_valid stays 1 and no fetch latency is exposed.
  - Prefetch is not issued beyond ZONE_LIMIT.
  - frame_start discards the shadow.
- Undefined: fetch on demand as above; dl_valid is low for the fetch duration.

Decomposition:
- Package maria_dma_pkg:
  - dll_state_t enum.
  - dll_entry_t packed struct {dli, holey[1:0], rsvd, offset[3:0], dl_hi, dl_lo}.
  - DMA_ON_CODE localparam default and DLL_ENTRY_BYTES=3.
- One sub-module, dll_byte_reader: single-byte req/ack engine holding mem_req/mem_addr and returning byte + done. dll_fetch sequences it three times.

Test Plan:
1. ctrl=8'h40, zp=16'h1800, frame_start; memory 1800:{8'h82,8'h20,8'h00}, ack 2 cycles after req -> dl_ptr=16'h2000, dl_offset=2, dl_holey=0, dl_valid=1, busy=0; line_starts -> offset 1, then 0 with dli pulse; next line_start fetches from 16'h1803.
2. zp=16'hFFFE, entry bytes at FFFE, FFFF, 0000 -> third read addresses 16'h0000; next entry read at 16'h0001.
3. line_start injected between F1 ack and F2 ack, entry offset=3 -> READY shows offset 2; two line_starts during fetch -> still offset 2.
4. ctrl changed to 8'h60 during F1 with req pending -> next cycle mem_req=0, dl_valid=0, busy=0; later ack ignored; frame_start with ctrl=8'h40 restarts at zp.
5. Async reset_n low mid-F2, no clock edge -> all outputs 0 immediately; after release, outputs stay 0 until frame_start.
6. With DLL_PREFETCH_EN defined and entries offset=0,0 -> dl_valid never drops across the zone boundary; dl_ptr switches on the line_start cycle.
